// File: rtl/cardinal_nic_pkg.sv
// cardinal_nic_pkg: shared register map, status/VC bit positions and sequencer state types
package cardinal_nic_pkg;
  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;
  localparam int STATUS_BIT = 63;
  localparam int VC_BIT     = 0;
  typedef enum logic [2:0] {IDLE, POLL_IN, READ_IN, POLL_OUT, WRITE_OUT} nic_state_e;
  typedef enum logic {RR_RX, RR_TX} rr_e;
endpackage

// File: rtl/cardinal_pkt_reg.sv
// cardinal_pkt_reg: one-entry valid/ready holding register for received packets
module cardinal_pkt_reg #(
  parameter int PACKET_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [0:PACKET_SIZE-1] load_data,
  output logic                   valid,
  output logic [0:PACKET_SIZE-1] data,
  input  logic                   ready
);
  // A load wins over a same-cycle pop; data only changes on load so it is stable while valid
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= load || (valid && !ready);
      if (load) data <= load_data;
    end
endmodule

// File: rtl/cardinal_nic_ctrl.sv
// cardinal_nic_ctrl: round-robin RX/TX sequencer for the NIC register port; CARDINAL_NIC_CTRL_STATS_EN adds packet counters
module cardinal_nic_ctrl
  import cardinal_nic_pkg::*;
#(
  parameter int PACKET_SIZE = 64
`ifdef CARDINAL_NIC_CTRL_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [0:1]             nic_addr,
  output logic                   nic_en,
  output logic                   nic_en_wr,
  output logic [0:PACKET_SIZE-1] nic_d_in,
  input  logic [0:PACKET_SIZE-1] nic_d_out,
  input  logic                   tx_valid,
  input  logic [0:PACKET_SIZE-1] tx_data,
  output logic                   tx_ready,
  output logic                   rx_valid,
  output logic [0:PACKET_SIZE-1] rx_data,
  input  logic                   rx_ready
`ifdef CARDINAL_NIC_CTRL_STATS_EN
  , output logic [CNT_W-1:0]     tx_count
  , output logic [CNT_W-1:0]     rx_count
`endif
);
  nic_state_e state, state_nx;
  rr_e        rr, rr_nx;
  logic       rx_elig;

  assign rx_elig = !rx_valid || rx_ready;

  // State and round-robin pointer registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      rr    <= RR_RX;
    end else begin
      state <= state_nx;
      rr    <= rr_nx;
    end

  // Next-state: arbitrate in IDLE, act on the polled status bit, hand priority to the other side after a poll
  always_comb begin
    state_nx = state;
    rr_nx    = rr;
    unique case (state)
      IDLE:      state_nx = (rx_elig && (!tx_valid || rr == RR_RX)) ? POLL_IN : tx_valid ? POLL_OUT : IDLE;
      POLL_IN: begin
        state_nx = nic_d_out[STATUS_BIT] ? READ_IN : IDLE;
        rr_nx    = RR_TX;
      end
      READ_IN:   state_nx = IDLE;
      POLL_OUT: begin
        state_nx = (!nic_d_out[STATUS_BIT] && tx_valid) ? WRITE_OUT : IDLE;
        rr_nx    = RR_RX;
      end
      WRITE_OUT: state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // NIC port is decoded from the state register alone, so reset clears it without waiting for a clock
  assign nic_en    = state != IDLE;
  assign nic_en_wr = state == WRITE_OUT;
  assign tx_ready  = state == WRITE_OUT;
  assign nic_addr  = state == POLL_IN   ? ADDR_IN_STAT  :
                     state == POLL_OUT  ? ADDR_OUT_STAT :
                     state == WRITE_OUT ? ADDR_OUT_BUF  : ADDR_IN_BUF;
  assign nic_d_in  = tx_ready ? tx_data : '0;

  cardinal_pkt_reg #(.PACKET_SIZE(PACKET_SIZE)) u_rx_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (state == READ_IN),
    .load_data (nic_d_out),
    .valid     (rx_valid),
    .data      (rx_data),
    .ready     (rx_ready)
  );

`ifdef CARDINAL_NIC_CTRL_STATS_EN
  // Free-running wrap-around transfer counters
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      tx_count <= tx_count + CNT_W'(state == WRITE_OUT);
      rx_count <= rx_count + CNT_W'(state == READ_IN);
    end
`endif
endmodule

// File: doc/cardinal_nic_ctrl.md
# cardinal_nic_ctrl

Sequencer that owns the processor-side register port of `cardinal_nic` and shares it between a transmit client and a receive client.

- It polls the NIC input and output status registers.
- It drains the input buffer into a one-entry RX holding register and pushes TX packets into the output buffer.
- It arbitrates the two directions round-robin.
- It sits between the NIC and the processor/traffic logic, replacing software polling of `addr`/`nicEn`/`nicEnWr`.

## Interface
- `PACKET_SIZE`, 64, packet width; bit 0 is the VC bit and bit `PACKET_SIZE-1` is the status bit in status reads.
- `CNT_W`, 16, width of the statistics counters (only with the stats macro).

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `nic_addr`  out  [0:1]  NIC register select.
- `nic_en`  out  1  NIC access enable.
- `nic_en_wr`  out  1  NIC write enable.
- `nic_d_in`  out  [0:PACKET_SIZE-1]  write data to NIC.
- `nic_d_out`  in  [0:PACKET_SIZE-1]  NIC read data; combinational from `nic_addr`.
- `tx_valid`  in  1  TX packet offered.
- `tx_data`  in  [0:PACKET_SIZE-1]  TX packet.
- `tx_ready`  out  1  TX packet accepted this cycle.
- `rx_valid`  out  1  RX packet held.
- `rx_data`  out  [0:PACKET_SIZE-1]  RX packet.
- `rx_ready`  in  1  RX consumer accepts.
- `tx_count`, `rx_count`  out  [CNT_W-1:0]  packet counters (stats build only).

## Operation
- **NIC register map:**
  - 00 = input buffer (a read with `nic_en` pops it and clears the input status).
  - 01 = input status (bit 63 = 1 means a packet is waiting).
  - 10 = output buffer (write).
  - 11 = output status (bit 63 = 1 means full).
- **FSM states:** IDLE, POLL_IN, READ_IN, POLL_OUT, WRITE_OUT.
- **Eligibility:**
  - RX is eligible when the holding register is free: `!rx_valid` or `rx_ready`.
  - TX is eligible when `tx_valid` is high.
- **IDLE:** `nic_en`=0.
  - If exactly one side is eligible, go to its poll state.
  - If both are eligible, the round-robin pointer `rr` picks the side.
  - If neither is eligible, stay in IDLE.
- **POLL_IN:** `nic_addr`=01, `nic_en`=1.
  - Status bit 1 → READ_IN.
  - Otherwise → IDLE.
  - `rr` points to TX afterwards.
- **READ_IN:** `nic_addr`=00, `nic_en`=1.
  - Capture `nic_d_out` into `rx_data` at the clock edge; `rx_valid`=1 next cycle.
  - Then → IDLE.
- **POLL_OUT:** `nic_addr`=11, `nic_en`=1.
  - Status bit 0 and `tx_valid` → WRITE_OUT.
  - Otherwise → IDLE.
  - `rr` points to RX afterwards.
- **WRITE_OUT:**
  - Drive `nic_addr`=10, `nic_en`=1, `nic_en_wr`=1, `nic_d_in`=`tx_data`.
  - `tx_ready`=1 (combinational, this state only).
  - Then → IDLE.
- **RX handshake:**
  - `rx_valid` stays high until `rx_valid && rx_ready`; then it clears next cycle, unless a READ_IN edge reloads it in the same cycle.
  - `rx_data` is stable while `rx_valid` is high.
- **TX handshake:**
  - The client holds `tx_valid`/`tx_data` until `tx_ready`.
  - If `tx_valid` drops before WRITE_OUT, no write occurs.
- **Packet contents:** packets pass unmodified, including the VC bit.

## Timing
- **Reset values:** state IDLE, `rr`=RX, `nic_addr`=00, `nic_en`=0, `nic_en_wr`=0, `nic_d_in`=0, `tx_ready`=0, `rx_valid`=0, `rx_data`=0, counters 0.
- **Registered outputs:** all NIC outputs are decoded from registered state only; no path from `nic_d_out` to `nic_addr` within a cycle.
- **TX latency:** `tx_valid` seen in IDLE at cycle c → POLL_OUT at c+1 → WRITE_OUT with `tx_ready` at c+2. Minimum 3 cycles per TX packet.
- **RX latency:** POLL_IN at n with status 1 → READ_IN at n+1 → `rx_valid` at n+2. Minimum 3 cycles per RX packet.
- **Continuous traffic:** with both sides saturated, the sequence alternates RX and TX, giving 6 cycles per RX+TX pair.
- **Reset mid-operation:** `nic_en_wr` and `nic_en` deassert immediately (asynchronously). A WRITE_OUT cut by reset is not retried, and the TX client sees no `tx_ready`.

## Configuration
- **`CARDINAL_NIC_CTRL_STATS_EN` defined:**
  - `tx_count` increments on each WRITE_OUT cycle.
  - `rx_count` increments on each READ_IN cycle.
  - Both wrap modulo 2^CNT_W and reset to 0.
- **Not defined:** the counter ports and logic are absent; all other behaviour is identical.

## Structure
- **Shared package `cardinal_nic_pkg`:**
  - Register address constants `ADDR_IN_BUF`, `ADDR_IN_STAT`, `ADDR_OUT_BUF`, `ADDR_OUT_STAT`.
  - `STATUS_BIT`=63.
  - `VC_BIT`=0.
  - FSM state enum.
- **Sub-module `cardinal_pkt_reg`:** one-entry valid/ready holding register for the RX side, parameterised by `PACKET_SIZE`.

## Test plan
- **Reset:** hold `reset`=0 mid-WRITE_OUT → `nic_en_wr`=0 immediately; after release, state IDLE and `rx_valid`=0.
- **Single TX:** output status 0, `tx_valid` with `tx_data`=0x8000_0000_0000_0005 → `tx_ready` and `nic_en_wr` high exactly at cycle c+2, `nic_d_in` equal to `tx_data`.
- **TX back-pressure:** output status bit 1 for 20 cycles → no `nic_en_wr`; POLL_OUT repeats; the write occurs 2 cycles after the status clears.
- **RX hold:** the NIC model supplies packets 0..9 with `rx_ready` low → one packet held, no further POLL_IN. Raising `rx_ready` delivers 0..9 in order with no loss.
- **Fairness:** both sides saturated for 100 cycles → RX and TX transfer counts differ by at most 1.
- **Stats:** with `CARDINAL_NIC_CTRL_STATS_EN`, `CNT_W`=4 and 17 TX packets → `tx_count`=1.
